// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM encoding, WM8731 register indices and the
// default codec device address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE_HI,
        ST_ACK_H,
        ST_BYTE_LO,
        ST_ACK_L,
        ST_IGNORE
    } i2c_state_e;

    localparam logic [6:0] CODEC_ADDR = 7'h1A;

    // WM8731 control register indices
    localparam logic [6:0] WM_R0_LLINE_IN  = 7'd0;
    localparam logic [6:0] WM_R1_RLINE_IN  = 7'd1;
    localparam logic [6:0] WM_R2_LHP_OUT   = 7'd2;
    localparam logic [6:0] WM_R3_RHP_OUT   = 7'd3;
    localparam logic [6:0] WM_R4_ANA_PATH  = 7'd4;
    localparam logic [6:0] WM_R5_DIG_PATH  = 7'd5;
    localparam logic [6:0] WM_R6_PWR_DOWN  = 7'd6;
    localparam logic [6:0] WM_R7_DIG_IF    = 7'd7;
    localparam logic [6:0] WM_R8_SAMPLING  = 7'd8;
    localparam logic [6:0] WM_R9_ACTIVE    = 7'd9;
    localparam logic [6:0] WM_R15_RESET    = 7'd15;

    // True when the address byte selects this device for a write.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr) && !addr_byte[0];
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with START/STOP and SCL edge detection; reusable by any
// oversampling I2C target.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Flops reset to 1 so a reset never looks like a bus condition.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s && !scl_prev_q;
    assign scl_fall_o = !scl_s && scl_prev_q;
    assign start_o    = scl_s && sda_prev_q && !sda_s;
    assign stop_o     = scl_s && !sda_prev_q && sda_s;

endmodule

// File: rtl/i2c_codec_slave.sv
// Write-only I2C target standing in for the audio codec control port: decodes
// {ADDR+W, REG_HI, REG_LO} frames into a 7-bit address, 9-bit value and a strobe.
module i2c_codec_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = CODEC_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iI2C_SCLK,
    input  logic       iI2C_SDAT,
    output logic       oI2C_SDAT_OE,
    output logic       oREG_WE,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oBUSY,
    output logic [7:0] oWR_COUNT
);

    logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i      (iCLK),
        .srst_i     (iRST),
        .scl_i      (iI2C_SCLK),
        .sda_i      (iI2C_SDAT),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hi_q, hi_d;
    logic       oe_q, oe_d;
    logic       commit_q, commit_d;
    logic       we_q;
    logic [6:0] addr_q;
    logic [8:0] data_q;
    logic [7:0] count_q;

    logic [7:0] byte_nxt;
    logic       byte_done;
    logic       in_byte;
    logic       in_ack;

    assign byte_nxt  = {shift_q[6:0], sda_s};
    assign byte_done = (bit_cnt_q == 3'd7);
    assign in_byte   = (state_q == ST_ADDR) || (state_q == ST_BYTE_HI) || (state_q == ST_BYTE_LO);
    assign in_ack    = (state_q == ST_ACK_A) || (state_q == ST_ACK_H) || (state_q == ST_ACK_L);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus conditions override bit events in every state.
    always_comb begin
        state_d = state_q;
        if (bus_stop) begin
            state_d = ST_IDLE;
        end else if (bus_start) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && byte_done) begin
                        state_d = addr_match(byte_nxt, SLAVE_ADDR) ? ST_ACK_A : ST_IGNORE;
                    end
                end
                ST_BYTE_HI: if (scl_rise && byte_done) state_d = ST_ACK_H;
                ST_BYTE_LO: if (scl_rise && byte_done) state_d = ST_ACK_L;
                ST_ACK_A:   if (scl_fall && oe_q) state_d = ST_BYTE_HI;
                ST_ACK_H:   if (scl_fall && oe_q) state_d = ST_BYTE_LO;
                ST_ACK_L:   if (scl_fall && oe_q) state_d = ST_IGNORE;
                default:    state_d = state_q;
            endcase
        end
    end

    // oe_q doubles as the ACK phase flag: first SCL fall pulls SDA, second releases it.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hi_d      = hi_q;
        oe_d      = oe_q;
        commit_d  = 1'b0;
        if (bus_start || bus_stop) begin
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
        end else begin
            if (scl_rise && in_byte) begin
                shift_d   = byte_nxt;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done && (state_q == ST_BYTE_HI)) hi_d = byte_nxt;
                if (byte_done && (state_q == ST_BYTE_LO)) commit_d = 1'b1;
            end
            if (scl_fall && in_ack) begin
                oe_d = !oe_q;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            hi_q      <= 8'd0;
            oe_q      <= 1'b0;
            commit_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 7'd0;
            data_q    <= 9'd0;
            count_q   <= 8'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hi_q      <= hi_d;
            oe_q      <= oe_d;
            commit_q  <= commit_d;
            we_q      <= commit_q;
            if (commit_q) begin
                addr_q  <= hi_q[7:1];
                data_q  <= {hi_q[0], shift_q};
                count_q <= count_q + 8'd1;
            end
        end
    end

    always_comb begin
        oI2C_SDAT_OE = oe_q;
        oREG_WE      = we_q;
        oREG_ADDR    = addr_q;
        oREG_DATA    = data_q;
        oBUSY        = (state_q != ST_IDLE);
        oWR_COUNT    = count_q;
    end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Bench for i2c_codec_slave: a bit-banged I2C master drives frames while a
// frame-level model predicts ACKs, strobes, held register values and the write count.
module tb_i2c_codec_slave;

    localparam int         SYNC     = 2;
    localparam logic [6:0] DEV_ADDR = 7'h1A;
    localparam logic [7:0] WR_BYTE  = {DEV_ADDR, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       oe;
    logic       we;
    logic [6:0] addr;
    logic [8:0] data;
    logic       busy;
    logic [7:0] cnt;

    assign sda_bus = sda_m & ~oe;

    always #5 clk = ~clk;

    i2c_codec_slave #(
        .SLAVE_ADDR  (DEV_ADDR),
        .SYNC_STAGES (SYNC)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iI2C_SCLK    (scl_m),
        .iI2C_SDAT    (sda_bus),
        .oI2C_SDAT_OE (oe),
        .oREG_WE      (we),
        .oREG_ADDR    (addr),
        .oREG_DATA    (data),
        .oBUSY        (busy),
        .oWR_COUNT    (cnt)
    );

    int     checks = 0;
    int     errors = 0;
    int     half   = 10;
    int     q      = 5;
    longint cyc    = 0;
    longint last_rise = 0;
    longint lat_last  = 0;
    int     we_seen   = 0;

    // Frame-level reference state
    int         m_count = 0;
    logic [6:0] m_addr  = 7'd0;
    logic [8:0] m_data  = 9'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            we_seen  = we_seen + 1;
            lat_last = cyc - last_rise;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        tick(q + 1); sda_m = 1'b1;
        tick(q);     scl_m = 1'b1;
        tick(q);     sda_m = 1'b0;
        tick(q);     scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(q); sda_m = 1'b0;
        tick(q); scl_m = 1'b1;
        tick(q); sda_m = 1'b1;
        tick(q);
    endtask

    task automatic clock_bit(input logic b, input bit is_data, output logic sampled);
        tick(q); sda_m = b;
        tick(half - q); scl_m = 1'b1;
        if (is_data) last_rise = cyc;
        tick(q); sampled = sda_bus;
        tick(half - q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b1, s);
        clock_bit(1'b1, 1'b0, s);
        ack = !s;
    endtask

    // One frame of n bytes; the model decides ACKs and the resulting write.
    task automatic run_frame(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input bit do_stop);
        logic [7:0] bytes [4];
        logic       ack;
        logic       exp_ack;
        bit         selected;
        bit         strobe;
        int         we_before;
        bytes     = '{b0, b1, b2, b3};
        selected  = (b0 == WR_BYTE);
        strobe    = selected && (n >= 3);
        we_before = we_seen;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], ack);
            exp_ack = selected && (i < 3);
            check($sformatf("%s ack%0d", tag, i), {31'd0, ack}, {31'd0, exp_ack});
            if (i == 0) check($sformatf("%s busy", tag), {31'd0, busy}, 32'd1);
        end
        if (strobe) begin
            m_count = (m_count + 1) % 256;
            m_addr  = 7'(b1 / 2);
            m_data  = 9'((b1 % 2) * 256 + b2);
        end
        tick(SYNC + 3);
        check($sformatf("%s strobes", tag), we_seen - we_before, strobe ? 32'd1 : 32'd0);
        if (strobe) check($sformatf("%s latency", tag), 32'(lat_last), SYNC + 2);
        check($sformatf("%s addr", tag), {25'd0, addr}, {25'd0, m_addr});
        check($sformatf("%s data", tag), {23'd0, data}, {23'd0, m_data});
        check($sformatf("%s count", tag), {24'd0, cnt}, 32'(m_count));
        if (do_stop) begin
            i2c_stop();
            tick(SYNC + 3);
            check($sformatf("%s busy_after_stop", tag), {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0] hb;
        logic       ack;
        logic       s;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        tick(4);
        check("reset oe",    {31'd0, oe},   32'd0);
        check("reset we",    {31'd0, we},   32'd0);
        check("reset addr",  {25'd0, addr}, 32'd0);
        check("reset data",  {23'd0, data}, 32'd0);
        check("reset busy",  {31'd0, busy}, 32'd0);
        check("reset count", {24'd0, cnt},  32'd0);
        rst = 1'b0;
        tick(5);

        run_frame("w1", 3, 8'h34, 8'h00, 8'h17, 8'h00, 1'b1);
        check("w1 addr_const",  {25'd0, addr}, 32'd0);
        check("w1 data_const",  {23'd0, data}, 32'h017);
        check("w1 count_const", {24'd0, cnt},  32'd1);
        run_frame("w2", 3, 8'h34, 8'h12, 8'h01, 8'h00, 1'b1);
        check("w2 addr_const", {25'd0, addr}, 32'd9);
        check("w2 data_const", {23'd0, data}, 32'h001);
        run_frame("w3", 3, 8'h34, 8'h08, 8'hD2, 8'h00, 1'b1);
        check("w3 addr_const", {25'd0, addr}, 32'd4);
        check("w3 data_const", {23'd0, data}, 32'h0D2);
        run_frame("wrong_addr", 3, 8'h36, 8'h00, 8'h17, 8'h00, 1'b1);
        run_frame("read", 1, 8'h35, 8'h00, 8'h00, 8'h00, 1'b1);
        run_frame("short", 2, 8'h34, 8'h0E, 8'h00, 8'h00, 1'b1);
        run_frame("rs_part", 2, 8'h34, 8'h0E, 8'h00, 8'h00, 1'b0);
        run_frame("rs_full", 3, 8'h34, 8'h0E, 8'h01, 8'h00, 1'b1);
        check("rs addr_const", {25'd0, addr}, 32'd7);
        check("rs data_const", {23'd0, data}, 32'h001);
        run_frame("extra_byte", 4, 8'h34, 8'h1E, 8'h00, 8'hA5, 1'b1);

        for (int k = 0; k < 4; k++) begin
            run_frame("rand_addr", 1 + (k % 4), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        end

        // Reset in the middle of the REG_HI acknowledge.
        hb = 8'h0E;
        i2c_start();
        send_byte(WR_BYTE, ack);
        check("rst addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 7; i >= 0; i--) clock_bit(hb[i], 1'b1, s);
        tick(q); sda_m = 1'b1;
        tick(2);
        check("rst oe_in_ack_h", {31'd0, oe}, 32'd1);
        rst = 1'b1;
        tick(1);
        check("rst oe_released", {31'd0, oe},   32'd0);
        check("rst busy_clear",  {31'd0, busy}, 32'd0);
        check("rst count_clear", {24'd0, cnt},  32'd0);
        rst = 1'b0;
        m_count = 0; m_addr = 7'd0; m_data = 9'd0;
        tick(half - q - 3); scl_m = 1'b1;
        tick(half);         scl_m = 1'b0;
        i2c_stop();
        tick(SYNC + 3);
        run_frame("after_rst", 3, 8'h34, 8'h10, 8'h3F, 8'h00, 1'b1);
        check("after_rst addr_const", {25'd0, addr}, 32'd8);
        check("after_rst data_const", {23'd0, data}, 32'h03F);

        // Back-to-back writes chained by repeated STARTs until the counter wraps.
        half = 5; q = 2;
        for (int k = 0; k < 256; k++) begin
            run_frame("wrap", 3, WR_BYTE, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'h00, k == 255);
            if (m_count == 0) check("wrap_zero", {24'd0, cnt}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
